// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline.
// Detects load-use and multi-cycle (mul/div) hazards in ID and emits stall
// and flush controls. A taken EX/MEM branch redirect overrides every stall.
// The instruction in ID moves on ("issues") only when it is valid, no hazard
// holds it back, and no redirect is squashing it in the same cycle. A single
// multi-cycle unit is tracked by a two-state FSM, which is visible on mc_busy.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs1,
    input  logic [AW-1:0]     id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              id_is_mc,
    input  logic              mc_done,
    input  logic              ex_mem_taken,
    output logic              pc_from_taken,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mc_kill,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic [2:0] LOAD_CNT = 3'(LOAD_LAT);

    logic [2:0]    cnt [NREG];
    mc_state_t     state_q, state_d;
    logic [AW-1:0] mc_rd_q, mc_rd_d;
    logic [AW-1:0] last_rd;
    logic          last_load_issued;
    logic          last_mc_issued;

    logic rs1_pending, rs2_pending;
    logic load_haz, mc_haz, stall, issue;
    logic load_set, squash_load, kill_raw;

    // Look up the pending-load counters of both sources; x0 is never pending.
    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (id_rs1 == AW'(i) && cnt[i] != 3'd0) rs1_pending = 1'b1;
            if (id_rs2 == AW'(i) && cnt[i] != 3'd0) rs2_pending = 1'b1;
        end
    end

    assign load_haz = id_valid & ((id_rs1_used & rs1_pending) |
                                  (id_rs2_used & rs2_pending));

    // In MC_BUSY, hold RAW/WAW on the mc destination and any second mc op;
    // the mc_done cycle forwards the result so nothing needs to wait.
    assign mc_haz = (state_q == MC_BUSY) & id_valid & ~mc_done &
                    ((id_rs1_used & (mc_rd_q != '0) & (id_rs1 == mc_rd_q)) |
                     (id_rs2_used & (mc_rd_q != '0) & (id_rs2 == mc_rd_q)) |
                     (id_we       & (mc_rd_q != '0) & (id_rd  == mc_rd_q)) |
                     id_is_mc);

    assign stall       = load_haz | mc_haz;
    assign issue       = id_valid & ~stall & ~ex_mem_taken;
    assign load_set    = issue & id_is_load & id_we & (id_rd != '0);
    assign squash_load = ex_mem_taken & last_load_issued;
    // Only the mc op issued last cycle is on the wrong path; an older one is not.
    assign kill_raw    = ex_mem_taken & last_mc_issued;

    // Per-register load countdown: squash clears, a new load reloads, else decay.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                cnt[i] <= 3'd0;
            end else if (squash_load && last_rd == AW'(i)) begin
                cnt[i] <= 3'd0;
            end else if (load_set && id_rd == AW'(i)) begin
                cnt[i] <= LOAD_CNT;
            end else if (cnt[i] != 3'd0) begin
                cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // Remember what issued last cycle so a redirect can undo it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd          <= '0;
            last_load_issued <= 1'b0;
            last_mc_issued   <= 1'b0;
        end else begin
            last_rd          <= id_rd;
            last_load_issued <= load_set;
            last_mc_issued   <= issue & id_is_mc;
        end
    end

    // Multi-cycle FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    // Multi-cycle FSM next state: a kill wins, a new mc op re-arms, done retires.
    always_comb begin
        state_d = state_q;
        mc_rd_d = mc_rd_q;
        case (state_q)
            IDLE: begin
                if (issue && id_is_mc) begin
                    state_d = MC_BUSY;
                    mc_rd_d = id_we ? id_rd : '0;
                end
            end
            MC_BUSY: begin
                if (kill_raw) begin
                    state_d = IDLE;
                end else if (issue && id_is_mc) begin
                    state_d = MC_BUSY;
                    mc_rd_d = id_we ? id_rd : '0;
                end else if (mc_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline controls; all forced low while reset is asserted.
    assign pc_from_taken = ~rst & ex_mem_taken;
    assign pc_stall      = ~rst & ~ex_mem_taken & stall;
    assign if_id_stall   = ~rst & ~ex_mem_taken & stall;
    assign if_id_flush   = ~rst & ex_mem_taken;
    assign id_ex_flush   = ~rst & (ex_mem_taken | stall);
    assign ex_mem_flush  = ~rst & ex_mem_taken;
    assign mc_kill       = ~rst & kill_raw;
    assign mc_busy       = ~rst & (state_q == MC_BUSY);

    // Saturating count of cycles spent stalled (redirect cycles excluded).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && !ex_mem_taken && !(&stall_count)) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. Two instances share the ID-stage inputs:
// dut_a (LOAD_LAT=1, PERF_W=4) and dut_b (LOAD_LAT=3, PERF_W=32).
// Each scenario lists per-cycle stimulus with the expected control vector
// {pc_from_taken, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
//  ex_mem_flush, mc_kill, mc_busy}.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mc;
    logic       done;
    logic       tk;
  } stim_t;

  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_STALL = 8'b0110_1000;
  localparam logic [7:0] C_TAKEN = 8'b1001_1100;
  localparam logic [7:0] C_KILL  = 8'b0000_0010;
  localparam logic [7:0] C_BUSY  = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_is_mc;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       mc_done, ex_mem_taken;

  logic        a_pft, a_pcs, a_ifs, a_iff, a_ief, a_emf, a_kill, a_busy;
  logic        b_pft, b_pcs, b_ifs, b_iff, b_ief, b_emf, b_kill, b_busy;
  logic [3:0]  stall_count_a;
  logic [31:0] stall_count_b;
  logic [7:0]  ctl_a, ctl_b;

  logic [7:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  assign ctl_a = {a_pft, a_pcs, a_ifs, a_iff, a_ief, a_emf, a_kill, a_busy};
  assign ctl_b = {b_pft, b_pcs, b_ifs, b_iff, b_ief, b_emf, b_kill, b_busy};

  hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .PERF_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .mc_done(mc_done), .ex_mem_taken(ex_mem_taken),
    .pc_from_taken(a_pft), .pc_stall(a_pcs), .if_id_stall(a_ifs), .if_id_flush(a_iff),
    .id_ex_flush(a_ief), .ex_mem_flush(a_emf), .mc_kill(a_kill), .mc_busy(a_busy),
    .stall_count(stall_count_a)
  );

  hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(3), .PERF_W(32)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .mc_done(mc_done), .ex_mem_taken(ex_mem_taken),
    .pc_from_taken(b_pft), .pc_stall(b_pcs), .if_id_stall(b_ifs), .if_id_flush(b_iff),
    .id_ex_flush(b_ief), .ex_mem_flush(b_emf), .mc_kill(b_kill), .mc_busy(b_busy),
    .stall_count(stall_count_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic stim_t op(int v, int rs1, int u1, int rs2, int u2, int rd,
                               int we, int ld, int mc, int done, int tk);
    stim_t s;
    s.rst  = 1'b0;
    s.v    = v[0];
    s.rs1  = 5'(rs1);
    s.u1   = u1[0];
    s.rs2  = 5'(rs2);
    s.u2   = u2[0];
    s.rd   = 5'(rd);
    s.we   = we[0];
    s.ld   = ld[0];
    s.mc   = mc[0];
    s.done = done[0];
    s.tk   = tk[0];
    return s;
  endfunction

  function automatic stim_t nop();
    return op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t alu(int rs1, int rd);
    return op(1, rs1, 1, 0, 0, rd, 1, 0, 0, 0, 0);
  endfunction

  function automatic stim_t load(int rd);
    return op(1, 1, 1, 0, 0, rd, 1, 1, 0, 0, 0);
  endfunction

  function automatic stim_t mcop(int rd);
    return op(1, 2, 1, 3, 1, rd, 1, 0, 1, 0, 0);
  endfunction

  task automatic apply(input stim_t s);
    rst          = s.rst;
    id_valid     = s.v;
    id_rs1       = s.rs1;
    id_rs1_used  = s.u1;
    id_rs2       = s.rs2;
    id_rs2_used  = s.u2;
    id_rd        = s.rd;
    id_we        = s.we;
    id_is_load   = s.ld;
    id_is_mc     = s.mc;
    mc_done      = s.done;
    ex_mem_taken = s.tk;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    stim_t s;
    s = nop();
    s.rst = 1'b1;
    apply(s);
    repeat (2) @(posedge clk);
    #1;
    apply(nop());
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    stim_t s;
    logic [7:0] exp;
    s = op(1, 5, 1, 6, 1, 7, 1, 1, 1, 1, 1);
    s.rst = 1'b1;
    apply(s);
    exp_q.push_back(C_NONE);
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (ctl_a !== exp) begin
      tests_failed++;
      $display("FAIL reset_ctl_a: got %b expected %b", ctl_a, exp);
    end
    tests_run++;
    if (ctl_b !== exp) begin
      tests_failed++;
      $display("FAIL reset_ctl_b: got %b expected %b", ctl_b, exp);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (stall_count_a !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_count_a: got %0d expected 0", stall_count_a);
    end
    apply(nop());
    exp_q.push_back(C_NONE);
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (ctl_a !== exp) begin
      tests_failed++;
      $display("FAIL post_reset_ctl_a: got %b expected %b", ctl_a, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_lat1();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    do_reset();
    s.push_back(load(5));                            w.push_back(C_NONE);
    s.push_back(alu(5, 6));                          w.push_back(C_STALL);
    s.push_back(alu(5, 6));                          w.push_back(C_NONE);
    s.push_back(load(5));                            w.push_back(C_NONE);
    s.push_back(op(1, 0, 0, 5, 0, 6, 1, 0, 0, 0, 0)); w.push_back(C_NONE);
    s.push_back(load(5));                            w.push_back(C_NONE);
    s.push_back(op(0, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0)); w.push_back(C_NONE);
    s.push_back(nop());                              w.push_back(C_NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_a !== exp) begin
        tests_failed++;
        $display("FAIL load_lat1 cycle %0d: got %b expected %b", i, ctl_a, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_lat3();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    do_reset();
    s.push_back(load(7));                            w.push_back(C_NONE);
    for (int k = 0; k < 3; k++) begin
      s.push_back(op(1, 3, 1, 7, 1, 8, 1, 0, 0, 0, 0)); w.push_back(C_STALL);
    end
    s.push_back(op(1, 3, 1, 7, 1, 8, 1, 0, 0, 0, 0)); w.push_back(C_NONE);
    s.push_back(load(0));                            w.push_back(C_NONE);
    s.push_back(alu(0, 8));                          w.push_back(C_NONE);
    s.push_back(nop());                              w.push_back(C_NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_b !== exp) begin
        tests_failed++;
        $display("FAIL load_lat3 cycle %0d: got %b expected %b", i, ctl_b, exp);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (stall_count_b !== 32'd3) begin
      tests_failed++;
      $display("FAIL load_lat3_count: got %0d expected 3", stall_count_b);
    end
  endtask

  task automatic test_mc();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    do_reset();
    s.push_back(mcop(9));                                  w.push_back(C_NONE);
    s.push_back(alu($urandom_range(13, 31), $urandom_range(13, 31)));
    w.push_back(C_BUSY);
    s.push_back(op(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0));       w.push_back(C_STALL | C_BUSY);
    s.push_back(alu(9, 6));                                w.push_back(C_STALL | C_BUSY);
    s.push_back(alu(9, 6));                                w.push_back(C_STALL | C_BUSY);
    s.push_back(op(1, 9, 1, 0, 0, 6, 1, 0, 0, 1, 0));       w.push_back(C_BUSY);
    s.push_back(nop());                                    w.push_back(C_NONE);
    s.push_back(mcop(14));                                 w.push_back(C_NONE);
    s.push_back(mcop(15));                                 w.push_back(C_STALL | C_BUSY);
    s.push_back(op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));       w.push_back(C_BUSY);
    s.push_back(nop());                                    w.push_back(C_NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_a !== exp) begin
        tests_failed++;
        $display("FAIL mc_hazard cycle %0d: got %b expected %b", i, ctl_a, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_taken_squash();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    do_reset();
    s.push_back(load(4));                             w.push_back(C_NONE);
    s.push_back(op(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 1)); w.push_back(C_TAKEN);
    s.push_back(alu(4, 6));                           w.push_back(C_NONE);
    s.push_back(op(1, 5, 1, 4, 1, 6, 1, 0, 0, 0, 0)); w.push_back(C_NONE);
    s.push_back(nop());                               w.push_back(C_NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_b !== exp) begin
        tests_failed++;
        $display("FAIL taken_squash cycle %0d: got %b expected %b", i, ctl_b, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mc_kill();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    stim_t r;
    do_reset();
    s.push_back(mcop(10));                                  w.push_back(C_NONE);
    s.push_back(op(1, 10, 1, 0, 0, 6, 1, 0, 0, 0, 1));       w.push_back(C_TAKEN | C_KILL | C_BUSY);
    s.push_back(nop());                                     w.push_back(C_NONE);
    s.push_back(mcop(11));                                  w.push_back(C_NONE);
    s.push_back(nop());                                     w.push_back(C_BUSY);
    s.push_back(op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));        w.push_back(C_TAKEN | C_BUSY);
    s.push_back(nop());                                     w.push_back(C_BUSY);
    s.push_back(op(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));        w.push_back(C_BUSY);
    s.push_back(nop());                                     w.push_back(C_NONE);
    s.push_back(mcop(13));                                  w.push_back(C_NONE);
    r = op(1, 13, 1, 0, 0, 6, 1, 0, 1, 0, 1);
    r.rst = 1'b1;
    s.push_back(r);                                         w.push_back(C_NONE);
    s.push_back(op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));        w.push_back(C_TAKEN);
    s.push_back(nop());                                     w.push_back(C_NONE);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_a !== exp) begin
        tests_failed++;
        $display("FAIL mc_kill cycle %0d: got %b expected %b", i, ctl_a, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back_stalls();
    stim_t s[$];
    logic [7:0] w[$];
    logic [7:0] exp;
    do_reset();
    s.push_back(mcop(12));                                  w.push_back(C_NONE);
    for (int k = 0; k < 20; k++) begin
      s.push_back(alu(12, 6));                              w.push_back(C_STALL | C_BUSY);
    end
    s.push_back(op(1, 12, 1, 0, 0, 6, 1, 0, 0, 1, 0));       w.push_back(C_BUSY);
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      exp_q.push_back(w[i]);
      @(negedge clk);
      exp = exp_q.pop_front();
      tests_run++;
      if (ctl_a !== exp) begin
        tests_failed++;
        $display("FAIL stall_run cycle %0d: got %b expected %b", i, ctl_a, exp);
      end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (stall_count_a !== 4'd15) begin
      tests_failed++;
      $display("FAIL stall_count_sat: got %0d expected 15", stall_count_a);
    end
    do_reset();
    tests_run++;
    if (stall_count_a !== 4'd0) begin
      tests_failed++;
      $display("FAIL stall_count_reset: got %0d expected 0", stall_count_a);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    apply(nop());
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_mc();
    test_taken_squash();
    test_mc_kill();
    test_back_to_back_stalls();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
